// File: rtl/panel_input_conditioner.sv
// Alarm-clock panel front end: sync, debounce, auto-repeat, pending counts.
// Define PANEL_AUTOREPEAT_EN to enable hold-to-repeat button events.
module panel_input_conditioner #(
  parameter int N_SW            = 4,
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] btn_ack,
  output logic [N_SW-1:0]  sw_level,
  output logic [N_BTN-1:0] btn_level,
  output logic [1:0]       btn_pending0,
  output logic [1:0]       btn_pending1
);

  localparam int NI = N_SW + N_BTN;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [N_BTN-1:0] BPOL =
    {N_BTN{BTN_ACTIVE_LOW != 0}};
  localparam logic [NI-1:0] IDLE_RAW =
    {BPOL, {N_SW{1'b0}}};

  logic [NI-1:0] s1;
  logic [NI-1:0] s2;
  logic [NI-1:0] norm;
  logic [NI-1:0] lvl;
  logic [CW-1:0] cnt [NI];

  // XOR with the idle raw level maps every input to 1 = active
  assign norm = s2 ^ IDLE_RAW;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= IDLE_RAW;
      s2  <= IDLE_RAW;
      lvl <= '0;
      for (int i = 0; i < NI; i++)
        cnt[i] <= '0;
    end else begin
      s1 <= {btn_raw, sw_raw};
      s2 <= s1;
      for (int i = 0; i < NI; i++) begin
        if (norm[i] == lvl[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] ==
                     CW'(DEBOUNCE_CYCLES - 1)) begin
          lvl[i] <= ~lvl[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign sw_level  = lvl[N_SW-1:0];
  assign btn_level = lvl[NI-1:N_SW];

  logic [2*N_BTN-1:0] pend_all;

  for (genvar b = 0; b < N_BTN; b++) begin : g_btn
    logic       pressed;
    logic       ev;
    logic       ack_q;
    logic       ack_rise;
    logic [1:0] pend;

    assign pressed  = lvl[N_SW+b];
    assign ack_rise = btn_ack[b] & ~ack_q;

`ifdef PANEL_AUTOREPEAT_EN
    localparam int TMAX =
      (REPEAT_DELAY > REPEAT_PERIOD) ?
      REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
      IDLE, HOLD, REPEAT
    } st_t;

    st_t           st;
    logic [TW-1:0] tmr;

    always_ff @(posedge clk) begin
      if (reset) begin
        st  <= IDLE;
        tmr <= '0;
        ev  <= 1'b0;
      end else begin
        ev <= 1'b0;
        unique case (st)
          IDLE: if (pressed) begin
            ev  <= 1'b1;
            tmr <= TW'(REPEAT_DELAY - 1);
            st  <= HOLD;
          end
          HOLD, REPEAT: begin
            if (!pressed) begin
              st <= IDLE;
            end else if (tmr == '0) begin
              ev  <= 1'b1;
              tmr <= TW'(REPEAT_PERIOD - 1);
              st  <= REPEAT;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
`else
    typedef enum logic {
      IDLE, HOLD
    } st_t;

    st_t st;

    always_ff @(posedge clk) begin
      if (reset) begin
        st <= IDLE;
        ev <= 1'b0;
      end else begin
        ev <= 1'b0;
        unique case (st)
          IDLE: if (pressed) begin
            ev <= 1'b1;
            st <= HOLD;
          end
          HOLD: if (!pressed) st <= IDLE;
          default: st <= IDLE;
        endcase
      end
    end
`endif

    // simultaneous event and ack cancel out
    always_ff @(posedge clk) begin
      if (reset) begin
        ack_q <= 1'b0;
        pend  <= 2'd0;
      end else begin
        ack_q <= btn_ack[b];
        unique case (1'b1)
          ev & ~ack_rise:
            if (pend != 2'd3) pend <= pend + 2'd1;
          ack_rise & ~ev:
            if (pend != 2'd0) pend <= pend - 2'd1;
          default: ;
        endcase
      end
    end

    assign pend_all[2*b +: 2] = pend;
  end

  assign btn_pending0 = pend_all[1:0];
  assign btn_pending1 = pend_all[3:2];

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Bench for panel_input_conditioner: vector table, corner
// sequences and a randomized run against a reference model.
module tb_panel_input_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
`ifdef PANEL_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw_raw = 4'h0;
  logic [1:0] btn_raw = 2'b11;
  logic [1:0] btn_ack = 2'b00;
  logic [3:0] sw_level;
  logic [1:0] btn_level;
  logic [1:0] btn_pending0;
  logic [1:0] btn_pending1;

  panel_input_conditioner #(
    .N_SW(4), .N_BTN(2),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .BTN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset),
    .sw_raw(sw_raw), .btn_raw(btn_raw),
    .btn_ack(btn_ack),
    .sw_level(sw_level), .btn_level(btn_level),
    .btn_pending0(btn_pending0),
    .btn_pending1(btn_pending1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int         at;
    logic [3:0] sw;
    logic [1:0] btn;
    logic [1:0] ack;
    logic [3:0] e_sw;
    logic [1:0] e_lvl;
    logic [1:0] e_p0;
    logic [1:0] e_p1;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic add(input int at,
                     input logic [3:0] sw,
                     input logic [1:0] btn,
                     input logic [1:0] ack,
                     input logic [3:0] esw,
                     input logic [1:0] elv,
                     input logic [1:0] ep0,
                     input logic [1:0] ep1);
    vec_t v;
    v.at = at; v.sw = sw; v.btn = btn; v.ack = ack;
    v.e_sw = esw; v.e_lvl = elv;
    v.e_p0 = ep0; v.e_p1 = ep1;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sw_raw = 4'h0;
    btn_raw = 2'b11;
    btn_ack = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  // reference model state
  logic [5:0] m_s1, m_s2, m_lvl;
  int         m_run [6];
  int         m_held [2];
  bit         m_ev [2];
  int         m_p [2];
  bit         m_aq [2];

  task automatic model_step(input logic r,
                            input logic [3:0] sw,
                            input logic [1:0] btn,
                            input logic [1:0] ack);
    logic [5:0] nrm;
    bit rise;
    bit lv;
    if (r) begin
      m_s1 = 6'b110000;
      m_s2 = 6'b110000;
      m_lvl = '0;
      for (int i = 0; i < 6; i++) m_run[i] = 0;
      for (int b = 0; b < 2; b++) begin
        m_held[b] = 0; m_ev[b] = 0;
        m_p[b] = 0; m_aq[b] = 0;
      end
      return;
    end
    for (int b = 0; b < 2; b++) begin
      rise = ack[b] && !m_aq[b];
      if (m_ev[b] && !rise)
        m_p[b] = (m_p[b] < 3) ? m_p[b] + 1 : 3;
      else if (rise && !m_ev[b] && m_p[b] > 0)
        m_p[b] = m_p[b] - 1;
      lv = m_lvl[4+b];
      m_held[b] = lv ? m_held[b] + 1 : 0;
      m_ev[b] = lv && (m_held[b] == 1 ||
        (AR && m_held[b] >= RD + 1 &&
         (m_held[b] - RD - 1) % RP == 0));
    end
    nrm = m_s2 ^ 6'b110000;
    for (int i = 0; i < 6; i++) begin
      if (nrm[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = {btn, sw};
    for (int b = 0; b < 2; b++) m_aq[b] = ack[b];
  endtask

  initial begin
    logic [1:0] q2, q3, a1, a2;
    logic [15:0] exp;
    bit r;

    q2 = AR ? 2'd2 : 2'd1;
    q3 = AR ? 2'd3 : 2'd1;
    a1 = AR ? 2'd2 : 2'd0;
    a2 = AR ? 2'd1 : 2'd0;

    add(0,   4'h0, 2'b10, 2'b00, 4'h0, 2'b00, 0, 0);
    add(5,   4'h0, 2'b10, 2'b00, 4'h0, 2'b00, 0, 0);
    add(6,   4'h0, 2'b10, 2'b00, 4'h0, 2'b01, 0, 0);
    add(7,   4'h0, 2'b10, 2'b00, 4'h0, 2'b01, 0, 0);
    add(8,   4'h0, 2'b10, 2'b00, 4'h0, 2'b01, 1, 0);
    add(27,  4'h0, 2'b10, 2'b00, 4'h0, 2'b01, 1, 0);
    add(28,  4'h0, 2'b10, 2'b00, 4'h0, 2'b01, q2, 0);
    add(35,  4'h0, 2'b10, 2'b00, 4'h0, 2'b01, q2, 0);
    add(36,  4'h0, 2'b10, 2'b00, 4'h0, 2'b01, q3, 0);
    add(60,  4'h0, 2'b11, 2'b00, 4'h0, 2'b01, q3, 0);
    add(65,  4'h0, 2'b11, 2'b00, 4'h0, 2'b01, q3, 0);
    add(66,  4'h0, 2'b11, 2'b00, 4'h0, 2'b00, q3, 0);
    add(70,  4'h0, 2'b11, 2'b01, 4'h0, 2'b00, q3, 0);
    add(71,  4'h0, 2'b11, 2'b01, 4'h0, 2'b00, a1, 0);
    add(75,  4'h0, 2'b11, 2'b00, 4'h0, 2'b00, a1, 0);
    add(78,  4'h0, 2'b11, 2'b01, 4'h0, 2'b00, a1, 0);
    add(79,  4'h0, 2'b11, 2'b01, 4'h0, 2'b00, a2, 0);
    add(84,  4'h0, 2'b11, 2'b00, 4'h0, 2'b00, a2, 0);
    add(90,  4'h0, 2'b01, 2'b00, 4'h0, 2'b00, a2, 0);
    add(93,  4'h0, 2'b11, 2'b00, 4'h0, 2'b00, a2, 0);
    add(95,  4'h0, 2'b11, 2'b00, 4'h0, 2'b00, a2, 0);
    add(100, 4'ha, 2'b11, 2'b00, 4'h0, 2'b00, a2, 0);
    add(105, 4'ha, 2'b11, 2'b00, 4'h0, 2'b00, a2, 0);
    add(106, 4'ha, 2'b11, 2'b00, 4'ha, 2'b00, a2, 0);
    add(110, 4'ha, 2'b11, 2'b00, 4'ha, 2'b00, a2, 0);

    do_reset();
    foreach (tbl[k]) begin
      while (cyc < tbl[k].at) tick();
      chk("tbl_sw", 16'(sw_level), 16'(tbl[k].e_sw));
      chk("tbl_lvl", 16'(btn_level), 16'(tbl[k].e_lvl));
      chk("tbl_p0", 16'(btn_pending0), 16'(tbl[k].e_p0));
      chk("tbl_p1", 16'(btn_pending1), 16'(tbl[k].e_p1));
      sw_raw = tbl[k].sw;
      btn_raw = tbl[k].btn;
      btn_ack = tbl[k].ack;
    end

    // event and ack in the same cycle, then reset mid-hold
    do_reset();
    btn_raw = 2'b10;
    while (cyc < 7) tick();
    btn_ack = 2'b01;
    tick();
    chk("evack_zero", 16'(btn_pending0), 16'd0);
    chk("evack_lvl", 16'(btn_level), 16'd1);
    while (cyc < 10) tick();
    btn_ack = 2'b00;
    while (cyc < 28) tick();
    chk("first_rep", 16'(btn_pending0), 16'(a2));
    while (cyc < 35) tick();
    btn_ack = 2'b01;
    tick();
    chk("evack_one", 16'(btn_pending0), 16'(a2));
    while (cyc < 40) tick();
    reset = 1'b1;
    btn_ack = 2'b00;
    tick();
    chk("rst_lvl", 16'(btn_level), 16'd0);
    chk("rst_p0", 16'(btn_pending0), 16'd0);
    chk("rst_p1", 16'(btn_pending1), 16'd0);
    chk("rst_sw", 16'(sw_level), 16'd0);
    reset = 1'b0;
    cyc = 0;
    while (cyc < 5) tick();
    chk("rehold_lvl5", 16'(btn_level), 16'd0);
    tick();
    chk("rehold_lvl6", 16'(btn_level), 16'd1);
    tick();
    chk("rehold_p0_7", 16'(btn_pending0), 16'd0);
    tick();
    chk("rehold_p0_8", 16'(btn_pending0), 16'd1);

    // randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      r = (i < 2) || ($urandom_range(0, 699) == 0);
      reset = r;
      for (int j = 0; j < 4; j++)
        if ($urandom_range(0, 11) == 0)
          sw_raw[j] = ~sw_raw[j];
      for (int j = 0; j < 2; j++) begin
        if ($urandom_range(0, 29) == 0)
          btn_raw[j] = ~btn_raw[j];
        if ($urandom_range(0, 5) == 0)
          btn_ack[j] = ~btn_ack[j];
      end
      model_step(r, sw_raw, btn_raw, btn_ack);
      tick();
      if (i >= 2) begin
        exp = {6'd0, m_lvl[3:0], m_lvl[5:4],
               2'(m_p[0]), 2'(m_p[1])};
        chk("rand", {6'd0, sw_level, btn_level,
                     btn_pending0, btn_pending1}, exp);
      end
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
